// File: rtl/uart_pkg.sv
// Shared constants for the UART serial engine.
//   - 2-bit FSM state encodings used by both the TX and RX machines
//   - RX_EMPTY: data-register read value when no received byte is held
//   - MIN_DIV:  smallest usable bit period, in clk cycles
//   - eff_div(): divisor clamp applied at every bit-counter reload
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [31:0] RX_EMPTY = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_DIV  = 32'd2;

  // The stored divisor is never clamped; only the value the counters use is.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational read port.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push, din  : write din when not full (or when full and popping this cycle)
//   pop, dout  : dout is the head entry; pop consumes it when not empty
//   full, empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// UART serial engine: divisor register, 8N1 transmitter fed by a TX FIFO,
// 8N1 receiver with a one-byte holding register.
//   clk, reset   : single rising-edge clock, synchronous active-high reset
//   ser_tx       : serial out, idle high
//   ser_rx       : serial in, asynchronous, double-flopped before use
//   reg_div_*    : byte-strobed divisor write, full readback
//   reg_dat_we   : push reg_dat_di[7:0] into the TX FIFO
//   reg_dat_re   : consume the RX holding register
//   reg_dat_do   : received byte zero-extended, or all ones when nothing held
//   reg_dat_wait : stall for a data write the FIFO cannot take this cycle
module uart_core
  import uart_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV = 32'd104,
  parameter int          TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  // ---------------- divisor ----------------
  logic [31:0] div_q, eff;

  always_ff @(posedge clk) begin
    if (reset) div_q <= DEFAULT_DIV;
    else
      for (int i = 0; i < 4; i++)
        if (reg_div_we[i]) div_q[8*i +: 8] <= reg_div_di[8*i +: 8];
  end

  assign reg_div_do = div_q;
  // Sampled only when a counter reloads, so a change never stretches a bit in flight.
  assign eff = eff_div(div_q);

  // ---------------- TX ----------------
  logic [1:0]  tx_state;
  logic [31:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        fifo_full, fifo_empty, tx_pop;
  logic [7:0]  fifo_dout;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^reg_dat_di[31:8];
  assign tx_pop        = (tx_state == ST_IDLE) && !fifo_empty;
  // The FIFO accepts a push into a full queue when a pop frees the slot in the
  // same cycle; wait stays low then so the adapter does not repeat the write.
  assign reg_dat_wait  = reg_dat_we && fifo_full && !tx_pop;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (reg_dat_we),
    .pop   (tx_pop),
    .din   (reg_dat_di[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx_cnt counts down the remaining cycles of the current bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      ser_tx   <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          ser_tx <= 1'b1;
          if (tx_pop) begin
            tx_sh    <= fifo_dout;
            ser_tx   <= 1'b0;
            tx_cnt   <= eff - 32'd1;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == '0) begin
            ser_tx   <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= eff - 32'd1;
            tx_state <= ST_DATA;
          end else tx_cnt <= tx_cnt - 32'd1;
        end
        ST_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= eff - 32'd1;
            if (tx_bit == 3'd7) begin
              ser_tx   <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              ser_tx <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end else tx_cnt <= tx_cnt - 32'd1;
        end
        ST_STOP: begin
          // Ends in IDLE; the single IDLE cycle is the gap before the next start.
          if (tx_cnt == '0) tx_state <= ST_IDLE;
          else              tx_cnt   <= tx_cnt - 32'd1;
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic        rx_s1, rx_s2;
  logic [1:0]  rx_state;
  logic [31:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_byte;
  logic        rx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (reg_dat_re && rx_valid) rx_valid <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (!rx_s2) begin
            // Half a bit puts every later sample near mid-bit.
            rx_cnt   <= (eff >> 1) - 32'd1;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) rx_state <= ST_IDLE;
            else begin
              rx_bit   <= '0;
              rx_cnt   <= eff - 32'd1;
              rx_state <= ST_DATA;
            end
          end else rx_cnt <= rx_cnt - 32'd1;
        end
        ST_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= eff - 32'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 32'd1;
        end
        ST_STOP: begin
          if (rx_cnt == '0) begin
            // A load wins over a same-cycle read: the reader got the old byte.
            if (rx_s2) begin
              rx_byte  <= rx_sh;
              rx_valid <= 1'b1;
            end
            rx_state <= ST_IDLE;
          end else rx_cnt <= rx_cnt - 32'd1;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  assign reg_dat_do = rx_valid ? {24'h0, rx_byte} : RX_EMPTY;

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ser_tx;
  logic        ser_rx = 1'b1;
  logic [3:0]  reg_div_we = '0;
  logic [31:0] reg_div_di = '0;
  logic [31:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = '0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] div_model;

  uart_core #(.DEFAULT_DIV(32'd104), .TX_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int eff_of(input logic [31:0] v);
    return (v < 32'd2) ? 2 : int'(v);
  endfunction

  // Line monitor: decodes 8N1 frames at mid-bit using mon_d; stores {stop, data}.
  bit         mon_en = 1'b1;
  int         mon_d  = 2;
  logic [8:0] tx_seen[$];
  int         start_cyc[$];

  initial begin : line_monitor
    logic       prev;
    logic [8:0] f;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && ser_tx === 1'b0) begin
        start_cyc.push_back(cyc);
        repeat (mon_d / 2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (mon_d) @(negedge clk);
          f[i] = ser_tx;
        end
        tx_seen.push_back(f);
      end
      prev = ser_tx;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; reg_div_we = '0; reg_dat_we = 1'b0; reg_dat_re = 1'b0; ser_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    div_model = 32'd104;
    mon_d = 104;
  endtask

  task automatic set_div(input logic [3:0] we, input logic [31:0] di);
    reg_div_we = we; reg_div_di = di;
    @(negedge clk);
    reg_div_we = '0;
    for (int j = 0; j < 4; j++)
      if (we[j]) div_model[8*j +: 8] = di[8*j +: 8];
    mon_d = eff_of(div_model);
  endtask

  // Adapter-style write: hold the request while wait is high.
  task automatic push_byte(input logic [7:0] b, output int waits);
    logic [31:0] r;
    r = $urandom();
    waits = 0;
    reg_dat_di = {r[31:8], b};
    reg_dat_we = 1'b1;
    #1;
    while (reg_dat_wait && waits < 3000) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 3000) begin
      errors++; checks++;
      $display("FAIL push_timeout: wait still high after %0d cycles, required low", waits);
    end
    @(negedge clk);
    reg_dat_we = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int d);
    ser_rx = 1'b0; repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i]; repeat (d) @(negedge clk);
    end
    ser_rx = stop; repeat (d) @(negedge clk);
    ser_rx = 1'b1; repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_first_edge_tx: got %b, required 1", ser_tx); end
    @(negedge clk);
    reset = 1'b0;
    div_model = 32'd104;
    checks++;
    if (reg_div_do !== 32'd104) begin errors++; $display("FAIL reset_div: got %h, required 00000068", reg_div_do); end
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_rx_empty: got %h, required ffffffff", reg_dat_do); end
    checks++;
    if (reg_dat_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b, required 0", reg_dat_wait); end
  endtask

  // Cycle-exact TX waveform: start low, data LSB first, stop high, each d cycles.
  task automatic test_tx_frame();
    logic [7:0] bytes[3];
    int         divs[3];
    int         w, bi, bad;
    logic       exp;
    bytes[0] = 8'h55; divs[0] = 4;
    bytes[1] = 8'($urandom()); divs[1] = $urandom_range(2, 6);
    bytes[2] = 8'($urandom()); divs[2] = $urandom_range(2, 6);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_div(4'hF, 32'(divs[c]));
      push_byte(bytes[c], w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL tx_push_wait c%0d: waited %0d, required 0", c, w); end
      checks++;
      if (ser_tx !== 1'b1) begin errors++; $display("FAIL tx_latency c%0d: got %b, required 1", c, ser_tx); end
      bad = 0;
      for (int k = 0; k < 10 * divs[c]; k++) begin
        @(negedge clk);
        bi  = k / divs[c];
        exp = (bi == 0) ? 1'b0 : (bi <= 8) ? bytes[c][bi-1] : 1'b1;
        checks++;
        if (ser_tx !== exp) begin
          errors++;
          if (bad++ < 4) $display("FAIL tx_wave c%0d cyc%0d: got %b, required %b", c, k, ser_tx, exp);
        end
      end
      @(negedge clk);
      checks++;
      if (ser_tx !== 1'b1) begin errors++; $display("FAIL tx_idle c%0d: got %b, required 1", c, ser_tx); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         w;
    do_reset();
    set_div(4'hF, 32'd8);
    tx_seen.delete(); start_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom()); exp_q.push_back(b);
      push_byte(b, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL b2b_push%0d_wait: waited %0d, required 0", i + 1, w); end
    end
    b = 8'($urandom()); exp_q.push_back(b);
    push_byte(b, w);
    checks++;
    if (w == 0) begin errors++; $display("FAIL b2b_push6_wait: waited %0d, required >0", w); end
    for (int t = 0; t < 3000 && tx_seen.size() < 6; t++) @(negedge clk);
    repeat (100) @(negedge clk);
    checks++;
    if (tx_seen.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d frames, required 6", tx_seen.size()); end
    for (int i = 0; i < 6 && i < tx_seen.size(); i++) begin
      checks++;
      if (tx_seen[i] !== {1'b1, exp_q[i]})
        begin errors++; $display("FAIL b2b_byte%0d: got %h, required %h", i, tx_seen[i], {1'b1, exp_q[i]}); end
    end
    for (int i = 0; i + 1 < start_cyc.size() && i < 5; i++) begin
      checks++;
      if (start_cyc[i+1] - start_cyc[i] != 81)
        begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles, required 81", i, start_cyc[i+1] - start_cyc[i]); end
    end
  endtask

  task automatic test_rx();
    logic [7:0] b, b2;
    int         d;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      b = (c == 0) ? 8'hA3 : 8'($urandom());
      d = (c == 0) ? 16 : $urandom_range(8, 20);
      set_div(4'hF, 32'(d));
      rx_send(b, 1'b1, d);
      #1;
      checks++;
      if (reg_dat_do !== {24'h0, b}) begin errors++; $display("FAIL rx_valid c%0d: got %h, required %h", c, reg_dat_do, {24'h0, b}); end
      reg_dat_re = 1'b1; #1;
      checks++;
      if (reg_dat_do !== {24'h0, b}) begin errors++; $display("FAIL rx_read c%0d: got %h, required %h", c, reg_dat_do, {24'h0, b}); end
      @(negedge clk); reg_dat_re = 1'b0; #1;
      checks++;
      if (reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_consumed c%0d: got %h, required ffffffff", c, reg_dat_do); end
    end
    // Overrun: the later byte replaces the unread one.
    b = 8'($urandom()); b2 = 8'($urandom());
    rx_send(b, 1'b1, d);
    rx_send(b2, 1'b1, d);
    #1;
    checks++;
    if (reg_dat_do !== {24'h0, b2}) begin errors++; $display("FAIL rx_overrun: got %h, required %h", reg_dat_do, {24'h0, b2}); end
    reg_dat_re = 1'b1;
    @(negedge clk); reg_dat_re = 1'b0;
  endtask

  task automatic test_rx_errors();
    logic [7:0] b;
    do_reset();
    set_div(4'hF, 32'd16);
    ser_rx = 1'b0; repeat (3) @(negedge clk);
    ser_rx = 1'b1; repeat (60) @(negedge clk);
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_glitch: got %h, required ffffffff", reg_dat_do); end
    rx_send(8'($urandom()), 1'b0, 16);
    repeat (48) @(negedge clk);
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_framing: got %h, required ffffffff", reg_dat_do); end
    b = 8'($urandom());
    rx_send(b, 1'b1, 16);
    #1;
    checks++;
    if (reg_dat_do !== {24'h0, b}) begin errors++; $display("FAIL rx_recover: got %h, required %h", reg_dat_do, {24'h0, b}); end
    reg_dat_re = 1'b1;
    @(negedge clk); reg_dat_re = 1'b0;
  endtask

  task automatic test_divisor();
    logic [7:0]  b;
    logic [31:0] di;
    logic        exp;
    int          w, bi, bad;
    do_reset();
    for (int v = 0; v < 2; v++) begin
      set_div(4'hF, 32'(v));
      checks++;
      if (reg_div_do !== 32'(v)) begin errors++; $display("FAIL div_readback%0d: got %h, required %h", v, reg_div_do, 32'(v)); end
      b = 8'($urandom());
      push_byte(b, w);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        bi  = k / 2;
        exp = (bi == 0) ? 1'b0 : (bi <= 8) ? b[bi-1] : 1'b1;
        checks++;
        if (ser_tx !== exp) begin
          errors++;
          if (bad++ < 4) $display("FAIL div_clamp%0d cyc%0d: got %b, required %b", v, k, ser_tx, exp);
        end
      end
      repeat (2) @(negedge clk);
    end
    do_reset();
    set_div(4'b0010, 32'h0000_AB00);
    checks++;
    if (reg_div_do !== 32'h0000_AB68) begin errors++; $display("FAIL div_strobe: got %h, required 0000ab68", reg_div_do); end
    for (int i = 0; i < 6; i++) begin
      di = $urandom();
      set_div(4'($urandom_range(0, 15)), di);
      checks++;
      if (reg_div_do !== div_model) begin errors++; $display("FAIL div_random%0d: got %h, required %h", i, reg_div_do, div_model); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int         w, lows;
    do_reset();
    set_div(4'hF, 32'd8);
    rx_send(8'h5A, 1'b1, 8);
    push_byte(8'h00, w);
    push_byte(8'($urandom()), w);
    push_byte(8'($urandom()), w);
    ser_rx = 1'b0;
    repeat (28) @(negedge clk);
    checks++;
    if (ser_tx !== 1'b0) begin errors++; $display("FAIL mid_precond_tx: got %b, required 0", ser_tx); end
    mon_en = 1'b0;
    reset = 1'b1; ser_rx = 1'b1;
    @(negedge clk);
    checks++;
    if (ser_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b, required 1", ser_tx); end
    checks++;
    if (reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_reset_rx: got %h, required ffffffff", reg_dat_do); end
    reset = 1'b0;
    div_model = 32'd104;
    lows = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL mid_fifo_empty: line low %0d cycles, required 0", lows); end
    checks++;
    if (reg_div_do !== 32'd104) begin errors++; $display("FAIL mid_div: got %h, required 00000068", reg_div_do); end
    set_div(4'hF, 32'd4);
    tx_seen.delete(); start_cyc.delete();
    mon_en = 1'b1;
    b = 8'($urandom());
    push_byte(b, w);
    repeat (60) @(negedge clk);
    checks++;
    if (tx_seen.size() != 1) begin errors++; $display("FAIL mid_after_count: got %0d frames, required 1", tx_seen.size()); end
    else begin
      checks++;
      if (tx_seen[0] !== {1'b1, b}) begin errors++; $display("FAIL mid_after_byte: got %h, required %h", tx_seen[0], {1'b1, b}); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_rx_errors();
    test_divisor();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
